// File: rtl/delay_pipe_pkg.sv
// Shared constants and helpers for the valid-tagged delay line.
// Used for both the default parameter values and the tap clamp.
package delay_pipe_pkg;

    // Bits needed to count 0..max_depth, for depth_sel and occupancy.
    function automatic int sel_w(input int max_depth);
        return $clog2(max_depth + 1);
    endfunction

    localparam int DEF_WIDTH     = 16;
    localparam int DEF_MAX_DEPTH = 8;
    localparam int DEF_SEL_W     = sel_w(DEF_MAX_DEPTH);

    // 0 behaves as 1. Anything past the physical depth uses the last stage.
    function automatic int clamp_tap(input int sel, input int max_depth);
        if (sel < 1)
            return 1;
        if (sel > max_depth)
            return max_depth;
        return sel;
    endfunction

endpackage

// File: rtl/delay_stage.sv
// One {valid, data} stage of the delay line.
// kill clears only the valid bit and takes priority over hold; gwe gates everything.
module delay_stage #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             gwe,
    input  logic             hold,
    input  logic             kill,
    input  logic             nxt_v,
    input  logic [WIDTH-1:0] nxt_d,
    output logic             v,
    output logic [WIDTH-1:0] d
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v <= 1'b0;
            d <= '0;
        end else if (gwe) begin
            if (kill) begin
                v <= 1'b0;
            end else if (!hold) begin
                v <= nxt_v;
                d <= nxt_d;
            end
        end
    end

endmodule

// File: rtl/delay_pipe_n.sv
// Delay line with valid tags, a run-time tap, stall/flush and an occupancy count.
// It delays tagged values so they line up with writeback.
module delay_pipe_n
    import delay_pipe_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int MAX_DEPTH = DEF_MAX_DEPTH,
    parameter int SEL_W     = DEF_SEL_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          gwe,
    input  logic                          stall,
    input  logic                          flush,
    input  logic [SEL_W-1:0]              depth_sel,
    input  logic                          in_valid,
    input  logic [WIDTH-1:0]              in_value,
    output logic                          out_valid,
    output logic [WIDTH-1:0]              out_value,
    output logic [sel_w(MAX_DEPTH)-1:0]   occupancy
);

    localparam int OCC_W = sel_w(MAX_DEPTH);

    // Index 0 is the input; index k is physical stage k.
    logic [MAX_DEPTH:0]            vld_pipe;
    logic [MAX_DEPTH:0][WIDTH-1:0] dat_pipe;

    assign vld_pipe[0] = in_valid;
    assign dat_pipe[0] = in_value;

    for (genvar k = 0; k < MAX_DEPTH; k++) begin : g_stg
        delay_stage #(
            .WIDTH (WIDTH)
        ) u_stg (
            .clk   (clk),
            .rst   (rst),
            .gwe   (gwe),
            .hold  (stall),
            .kill  (flush),
            .nxt_v (vld_pipe[k]),
            .nxt_d (dat_pipe[k]),
            .v     (vld_pipe[k+1]),
            .d     (dat_pipe[k+1])
        );
    end

    int               tap;
    logic             tap_v;
    logic [WIDTH-1:0] tap_d;
    logic [OCC_W-1:0] occ;

    // The tap moves with depth_sel straight away. Stages past it keep their
    // contents and show up again if the tap grows.
    always_comb begin
        tap   = clamp_tap(int'(depth_sel), MAX_DEPTH);
        tap_v = 1'b0;
        tap_d = '0;
        occ   = '0;
        for (int k = 1; k <= MAX_DEPTH; k++) begin
            if (k == tap) begin
                tap_v = vld_pipe[k];
                tap_d = dat_pipe[k];
            end
            if ((k <= tap) && vld_pipe[k])
                occ = occ + 1'b1;
        end
    end

    assign out_valid = tap_v;
    assign out_value = tap_v ? tap_d : '0;
    assign occupancy = occ;

endmodule

// File: tb/tb_delay_pipe_n.sv
// Directed bench for delay_pipe_n. Expected values go into a queue when they are
// driven and are compared when the tapped stage reports valid.
module tb_delay_pipe_n;

    localparam int WIDTH     = 16;
    localparam int MAX_DEPTH = 8;
    localparam int SEL_W     = 4;
    localparam int OCC_W     = $clog2(MAX_DEPTH + 1);

    logic             clk       = 1'b0;
    logic             rst       = 1'b0;
    logic             gwe       = 1'b1;
    logic             stall     = 1'b0;
    logic             flush     = 1'b0;
    logic [SEL_W-1:0] depth_sel = 4'd8;
    logic             in_valid  = 1'b0;
    logic [WIDTH-1:0] in_value  = '0;
    logic             out_valid;
    logic [WIDTH-1:0] out_value;
    logic [OCC_W-1:0] occupancy;

    int n_chk  = 0;
    int n_pass = 0;
    logic [WIDTH-1:0] sb[$];

    always #5 clk = ~clk;

    delay_pipe_n #(
        .WIDTH     (WIDTH),
        .MAX_DEPTH (MAX_DEPTH),
        .SEL_W     (SEL_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .gwe       (gwe),
        .stall     (stall),
        .flush     (flush),
        .depth_sel (depth_sel),
        .in_valid  (in_valid),
        .in_value  (in_value),
        .out_valid (out_valid),
        .out_value (out_value),
        .occupancy (occupancy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Each clock edge: valid output must match the queue head, and invalid output must be zero.
    task automatic step();
        @(posedge clk);
        #1;
        if (out_valid) begin
            if (sb.size() == 0)
                chk("sb_extra", 32'(out_valid), 32'd0);
            else
                chk("sb_data", 32'(out_value), 32'(sb.pop_front()));
        end else begin
            chk("mask", 32'(out_value), 32'd0);
        end
    endtask

    task automatic step_exp(input string tag, input logic ev);
        step();
        chk(tag, 32'(out_valid), 32'(ev));
    endtask

    task automatic push(input logic [WIDTH-1:0] v);
        in_valid = 1'b1;
        in_value = v;
        sb.push_back(v);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_value = WIDTH'($urandom);
    endtask

    task automatic do_flush();
        idle();
        flush = 1'b1;
        step();
        flush = 1'b0;
        sb.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Check that reset clears every output.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_value", 32'(out_value), 32'd0);
        chk("rst_occ",   32'(occupancy), 32'd0);
        rst = 1'b1;

        // Basic latency at full depth.
        depth_sel = 4'd8;
        push(16'hA5A5);
        step_exp("lat_e1", 1'b0);
        idle();
        for (int i = 2; i <= 7; i++) step_exp("lat_early", 1'b0);
        step_exp("lat_hit", 1'b1);
        step_exp("lat_once", 1'b0);

        // Tap 3 with a back-to-back stream.
        do_flush();
        depth_sel = 4'd3;
        push(16'd1); step_exp("tap3_e1", 1'b0);
        push(16'd2); step_exp("tap3_e2", 1'b0);
        push(16'd3); step_exp("tap3_o1", 1'b1);
        push(16'd4); step_exp("tap3_o2", 1'b1);
        idle();
        step_exp("tap3_o3", 1'b1);
        step_exp("tap3_o4", 1'b1);
        step_exp("tap3_end", 1'b0);

        // depth_sel 0 clamps to 1.
        do_flush();
        depth_sel = 4'd0;
        push(16'h0077);
        step_exp("tap0_hit", 1'b1);
        idle();
        step_exp("tap0_end", 1'b0);

        // depth_sel 15 clamps to 8.
        do_flush();
        depth_sel = 4'd15;
        push(16'h0088);
        step_exp("tap15_e1", 1'b0);
        idle();
        repeat (6) step_exp("tap15_early", 1'b0);
        step_exp("tap15_hit", 1'b1);
        step_exp("tap15_end", 1'b0);

        // Stall for two cycles, then gwe=0 with flush asserted: the entry must survive.
        do_flush();
        depth_sel = 4'd4;
        push(16'h0011);
        step_exp("st_e1", 1'b0);
        idle();
        step_exp("st_e2", 1'b0);
        chk("st_occ1", 32'(occupancy), 32'd1);
        stall = 1'b1; in_valid = 1'b1; in_value = 16'hDEAD;
        step_exp("st_hold1", 1'b0);
        step_exp("st_hold2", 1'b0);
        chk("st_occ_held", 32'(occupancy), 32'd1);
        stall = 1'b0; gwe = 1'b0; flush = 1'b1;
        step_exp("st_gwe0", 1'b0);
        chk("st_occ_gwe0", 32'(occupancy), 32'd1);
        gwe = 1'b1; flush = 1'b0;
        idle();
        step_exp("st_e6", 1'b0);
        step_exp("st_hit", 1'b1);
        repeat (5) step_exp("st_after", 1'b0);

        // Flush has priority over stall, and the input in that cycle is dropped.
        do_flush();
        depth_sel = 4'd4;
        for (int i = 0; i < 4; i++) begin
            push(WIDTH'(16'h21 + i));
            step_exp("fl_fill", i == 3);
        end
        chk("fl_occ4", 32'(occupancy), 32'd4);
        flush = 1'b1; stall = 1'b1; in_valid = 1'b1; in_value = 16'h0099;
        step();
        chk("fl_valid", 32'(out_valid), 32'd0);
        chk("fl_occ0",  32'(occupancy), 32'd0);
        flush = 1'b0; stall = 1'b0;
        sb.delete();
        idle();
        repeat (6) step_exp("fl_gone", 1'b0);

        // Shrinking the tap hides stages; growing it back shows them again.
        do_flush();
        depth_sel = 4'd8;
        for (int i = 0; i < 8; i++) begin
            push(WIDTH'(16'h100 + i));
            step_exp("sh_fill", i == 7);
        end
        idle();
        depth_sel = 4'd2;
        #1;
        chk("sh_occ",   32'(occupancy), 32'd2);
        chk("sh_valid", 32'(out_valid), 32'd1);
        chk("sh_value", 32'(out_value), 32'h106);
        depth_sel = 4'd8;
        #1;
        chk("sh_regrow", 32'(out_value), 32'h100);
        chk("sh_occ8",   32'(occupancy), 32'd8);
        do_flush();

        // Async reset between clock edges.
        depth_sel = 4'd5;
        for (int i = 0; i < 5; i++) begin
            push(WIDTH'(16'h200 + i));
            step_exp("ar_fill", i == 4);
        end
        idle();
        chk("ar_occ5", 32'(occupancy), 32'd5);
        #3;
        rst = 1'b0;
        #1;
        chk("ar_valid", 32'(out_valid), 32'd0);
        chk("ar_value", 32'(out_value), 32'd0);
        chk("ar_occ",   32'(occupancy), 32'd0);
        sb.delete();
        #2;
        rst = 1'b1;
        repeat (6) step_exp("ar_lost", 1'b0);
        chk("ar_occ_after", 32'(occupancy), 32'd0);

        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
